// File: rtl/core_launcher.sv
// Launch sequencer for the processor top: streams an image into data memory,
// holds the core in reset for a fixed period, then times the run until done or timeout.
`timescale 1ns/1ps
module core_launcher #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RESET_HOLD = 2,
  parameter int DONE_MASK  = 2,
  parameter int TIMEOUT    = 500,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              core_reset,
  input  logic              core_done,
  output logic              busy,
  output logic              finished,
  output logic              timed_out,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_TIMEOUT = 3'd5;

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  MASK_CNT  = CNT_W'(DONE_MASK);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  // One bit wider than the address so a full 2**ADDR_W image never wraps early.
  logic [ADDR_W:0]   byte_idx_q, byte_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [ADDR_W:0]   last_idx;

  assign last_idx = len_q - (ADDR_W+1)'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d       = state_q;
    len_d         = len_q;
    byte_idx_d    = byte_idx_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    dm_we_d       = 1'b0;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          len_d         = load_len;
          byte_idx_d    = '0;
          hold_cnt_d    = '0;
          cycle_count_d = '0;
          state_d       = (load_len != '0) ? S_LOAD : S_HOLD;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          dm_we_d    = 1'b1;
          dm_addr_d  = byte_idx_q[ADDR_W-1:0];
          dm_wdata_d = in_data;
          byte_idx_d = byte_idx_q + (ADDR_W+1)'(1);
          if (byte_idx_q == last_idx) begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        // Done beats timeout when both land on the same cycle; the count freezes.
        if (core_done && (cycle_count_q >= MASK_CNT)) begin
          state_d = S_DONE;
        end else begin
          if (cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
          end
          if (cycle_count_q == LAST_CNT) begin
            state_d = S_TIMEOUT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      byte_idx_q    <= '0;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byte_idx_q    <= byte_idx_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_RUN);
  assign core_reset  = (state_q != S_RUN);
  assign finished    = (state_q == S_DONE);
  assign timed_out   = (state_q == S_TIMEOUT);
  assign dm_we       = dm_we_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;
  assign cycle_count = cycle_count_q;

endmodule
